// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_resp_pkg
// Purpose  : Shared types, constants and address helpers for the memory-side
//            line responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        WACK  = 2'd3
    } state_e;

    localparam logic [31:0] c_INIT_PATTERN = 32'hC0DE_0000;

    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

    // line_words must be a power of two
    function automatic logic [31:0] line_base(input logic [31:0] byte_addr,
                                              input int unsigned line_words);
        return word_index(byte_addr) & ~(line_words - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_array
// Purpose  : Word storage for the responder; one write port, one asynchronous
//            read port, power-up image word[i] = C0DE_0000 | i.
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 9
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << IDX_W;

    function automatic logic [DATA_W-1:0] init_word(input logic [IDX_W-1:0] idx);
        return DATA_W'(c_INIT_PATTERN | 32'(idx));
    endfunction

    // Cells hold the difference from the power-up image, so zero-initialised
    // storage reads back as the pattern and no reset is needed.
    logic [DATA_W-1:0] delta_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            delta_q[wr_idx_i] <= wr_data_i ^ init_word(wr_idx_i);
        end
    end

    assign rd_data_o = delta_q[rd_idx_i] ^ init_word(rd_idx_i);

endmodule
`default_nettype wire

// File: rtl/mem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_line_responder
// Purpose  : Backing-store responder for the cache refill/write port: a full
//            line burst per read, a single ack beat per write.
// Config   : MEM_RESP_CRITICAL_WORD_FIRST_EN - burst starts at requested word
// Revision : 1.0 - initial release
// ============================================================================
module mem_line_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] c_LAT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [OFF_W-1:0] c_LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  base_q, base_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    logic              w_accept;
    logic              w_wr_en;
    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_req_base;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [OFF_W-1:0]  w_start_off;
    logic [OFF_W-1:0]  w_rd_off;
    logic [DATA_W-1:0] w_rd_data;

    // ready_q is only ever high while IDLE, so it alone qualifies acceptance
    assign w_accept   = req_valid && ready_q;
    assign w_wr_en    = w_accept && req_write;
    assign w_req_idx  = IDX_W'(word_index(32'(req_addr)));
    assign w_req_base = IDX_W'(line_base(32'(req_addr), LINE_WORDS));

`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    assign w_start_off = w_req_idx[OFF_W-1:0];
`else
    assign w_start_off = '0;
`endif

    // Look one beat ahead so the next word is ready when the current one is taken
    assign w_rd_off = (state_q == BURST) ? (off_q + beat_q + OFF_W'(1)) : off_q;
    assign w_rd_idx = base_q | IDX_W'(w_rd_off);

    mem_resp_array #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (w_wr_en),
        .wr_idx_i  (w_req_idx),
        .wr_data_i (req_wdata),
        .rd_idx_i  (w_rd_idx),
        .rd_data_o (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            base_q  <= '0;
            off_q   <= '0;
            beat_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            off_q   <= off_d;
            beat_q  <= beat_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        off_d   = off_q;
        beat_d  = beat_q;
        write_d = write_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = WAIT;
                    cnt_d   = c_LAT_LOAD;
                    base_d  = w_req_base;
                    off_d   = w_start_off;
                    beat_d  = '0;
                    write_d = req_write;
                    wdata_d = req_wdata;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (write_q) begin
                        state_d = WACK;
                        data_d  = wdata_q;
                        last_d  = 1'b1;
                    end else begin
                        state_d = BURST;
                        data_d  = w_rd_data;
                        last_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BURST: begin
                if (resp_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                        data_d = w_rd_data;
                        last_d = (beat_d == c_LAST_BEAT);
                    end
                end
            end
            WACK: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered so ready rises on the first edge after reset release
    assign ready_d = (state_d == IDLE);

    assign req_ready  = ready_q;
    assign resp_valid = (state_q == BURST) || (state_q == WACK);
    assign resp_data  = data_q;
    assign resp_last  = last_q;

endmodule
`default_nettype wire
